// File: rtl/dsadc_bcd_counter_pkg.sv
// dsadc_pkg: shared types and constants for the dual-slope ADC BCD time base.
//   DIGIT_W     - width of one BCD decade
//   BCD_MAX     - highest legal decade value
//   WRAP_SAT    - saturation value of the full-scale wrap counter
//   bcd_digit_t - one decade
//   wrap_cnt_t  - full-scale wrap counter
package dsadc_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef logic [1:0]         wrap_cnt_t;

    localparam wrap_cnt_t WRAP_SAT = 2'd3;

endpackage

// File: rtl/dsadc_bcd_counter_digit.sv
// dsadc_bcd_digit: one BCD decade of the time-base counter.
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   clr       - synchronous clear (conversion restart)
//   inc       - increment request (carry in)
//   digit     - current decade value, 0..9
//   carry_out - combinational carry to the next decade (inc while at 9)
module dsadc_bcd_digit
    import dsadc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out
);

    // Illegal codes 10..15 behave as 9 so a corrupted decade recovers on
    // its next increment instead of counting through garbage.
    logic at_max;

    assign at_max    = (digit >= BCD_MAX);
    assign carry_out = inc && at_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= at_max ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/dsadc_bcd_counter.sv
// dsadc_bcd_counter: decade time base for the dual-slope ADC.
// Counts clock cycles for integrate and run-down, pulses enb_3 on the first
// full-scale wrap, and latches the run-down count when enb_0 falls.
//   clk          - system clock, rising edge
//   rst_n        - synchronous active-low global reset
//   rst_s        - synchronous clear of the conversion counter (from FSM)
//   enb_0        - count enable (from FSM)
//   enb_3        - one-cycle pulse at the first full-scale wrap
//   count_bcd    - live count, digit 0 in bits [3:0]
//   result_bcd   - latched conversion result
//   result_over  - over-range flag belonging to result_bcd
//   result_valid - one-cycle pulse when result_bcd/result_over update
module dsadc_bcd_counter
    import dsadc_pkg::*;
#(
    parameter int unsigned N_DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rst_s,
    input  logic                        enb_0,
    output logic                        enb_3,
    output logic [DIGIT_W*N_DIGITS-1:0] count_bcd,
    output logic [DIGIT_W*N_DIGITS-1:0] result_bcd,
    output logic                        result_over,
    output logic                        result_valid
);

    logic [N_DIGITS:0] carry;
    logic              wrap;
    logic              fall;
    logic              enb_0_d;
    logic              ovf_flag;
    wrap_cnt_t         wrap_cnt;

    // Carries are combinational through every decade, so all digits move on
    // the same edge and the top carry is exactly the all-9s wrap event.
    assign carry[0] = enb_0;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        dsadc_bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (rst_s),
            .inc       (carry[g]),
            .digit     (count_bcd[DIGIT_W*g +: DIGIT_W]),
            .carry_out (carry[g+1])
        );
    end

    assign wrap = carry[N_DIGITS];
    assign fall = enb_0_d && !enb_0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enb_0_d      <= 1'b0;
            result_bcd   <= '0;
            result_over  <= 1'b0;
            result_valid <= 1'b0;
            enb_3        <= 1'b0;
            wrap_cnt     <= '0;
            ovf_flag     <= 1'b0;
        end else begin
            enb_0_d      <= enb_0;
            result_valid <= fall;

            // The latch reads the pre-clear count and overflow state, so a
            // simultaneous rst_s still reports the finished conversion.
            if (fall) begin
                result_bcd  <= count_bcd;
                result_over <= ovf_flag || (wrap_cnt == '0);
            end

            if (rst_s) begin
                wrap_cnt <= '0;
                ovf_flag <= 1'b0;
                enb_3    <= 1'b0;
            end else begin
                enb_3 <= wrap && (wrap_cnt == '0);
                if (wrap) begin
                    if (wrap_cnt != WRAP_SAT) begin
                        wrap_cnt <= wrap_cnt + 2'd1;
                    end
                    if (wrap_cnt != '0) begin
                        ovf_flag <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dsadc_bcd_counter.sv
// tb_dsadc_bcd_counter: self-checking bench for dsadc_bcd_counter.
// Table of run lengths with expected count/result, plus hand sequences for
// reset, simultaneous drop/clear and abort by global reset.
module tb_dsadc_bcd_counter;

    logic        clk;
    logic        rst_n;
    logic        rst_s;
    logic        enb_0;
    logic        enb_3;
    logic [11:0] count_bcd;
    logic [11:0] result_bcd;
    logic        result_over;
    logic        result_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    typedef struct {
        int          run;
        logic [11:0] exp_count;
        int          exp_pulses;
        logic        exp_over;
    } vec_t;

    typedef struct {
        logic [11:0] bcd;
        logic        over;
    } res_t;

    vec_t vecs[7];
    res_t sb[$];

    logic [11:0] prev_bcd;
    logic        prev_over;

    dsadc_bcd_counter #(.N_DIGITS(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rst_s        (rst_s),
        .enb_0        (enb_0),
        .enb_3        (enb_3),
        .count_bcd    (count_bcd),
        .result_bcd   (result_bcd),
        .result_over  (result_over),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and retire any produced
    // result against the scoreboard.
    task automatic step();
        res_t e;
        @(posedge clk);
        #1;
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(result_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result_bcd", 32'(result_bcd), 32'(e.bcd));
                check("result_over", 32'(result_over), 32'(e.over));
            end
        end
    endtask

    task automatic clear_run();
        rst_s = 1'b1;
        enb_0 = 1'b0;
        step();
        check("count_clr", 32'(count_bcd), 32'd0);
        check("enb3_clr", 32'(enb_3), 32'd0);
        rst_s = 1'b0;
        pulses = 0;
    endtask

    task automatic run_enb(input int n);
        for (int i = 1; i <= n; i++) begin
            enb_0 = 1'b1;
            step();
            if (enb_3 === 1'b1) begin
                pulses++;
                check("enb3_count_zero", 32'(count_bcd), 32'd0);
                check("enb3_edge", 32'(i), 32'd1000);
            end
            if (i == 1)   check("count_first", 32'(count_bcd), 32'h001);
            if (i == 999) check("count_999", 32'(count_bcd), 32'h999);
        end
    endtask

    task automatic drop(input logic [11:0] exp_count, input logic exp_over, input logic with_rst_s);
        res_t r;
        logic [11:0] exp_live;
        exp_live = with_rst_s ? 12'h000 : exp_count;
        r.bcd  = exp_count;
        r.over = exp_over;
        enb_0 = 1'b0;
        rst_s = with_rst_s;
        sb.push_back(r);
        step();
        check("valid_latency", 32'(result_valid), 32'd1);
        check("count_after_drop", 32'(count_bcd), 32'(exp_live));
        rst_s = 1'b0;
        step();
        check("valid_one_cycle", 32'(result_valid), 32'd0);
        check("count_hold", 32'(count_bcd), 32'(exp_live));
    endtask

    initial begin
        vecs[0] = '{run: 1437, exp_count: 12'h437, exp_pulses: 1, exp_over: 1'b0};
        vecs[1] = '{run: 2005, exp_count: 12'h005, exp_pulses: 1, exp_over: 1'b1};
        vecs[2] = '{run: 40,   exp_count: 12'h040, exp_pulses: 0, exp_over: 1'b1};
        vecs[3] = '{run: 1000, exp_count: 12'h000, exp_pulses: 1, exp_over: 1'b0};
        vecs[4] = '{run: 999,  exp_count: 12'h999, exp_pulses: 0, exp_over: 1'b1};
        vecs[5] = '{run: 1999, exp_count: 12'h999, exp_pulses: 1, exp_over: 1'b0};
        vecs[6] = '{run: 2000, exp_count: 12'h000, exp_pulses: 1, exp_over: 1'b1};

        // Reset with enable held high: everything stays zero.
        rst_n = 1'b0;
        rst_s = 1'b0;
        enb_0 = 1'b1;
        step();
        step();
        check("rst_count", 32'(count_bcd), 32'd0);
        check("rst_enb3", 32'(enb_3), 32'd0);
        check("rst_result", 32'(result_bcd), 32'd0);
        check("rst_over", 32'(result_over), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);

        // Release: counting starts straight from 000 without rst_s.
        rst_n = 1'b1;
        step();
        check("post_rst_count1", 32'(count_bcd), 32'h001);
        step();
        check("post_rst_count2", 32'(count_bcd), 32'h002);
        drop(12'h002, 1'b1, 1'b0);
        prev_bcd  = 12'h002;
        prev_over = 1'b1;

        foreach (vecs[k]) begin
            clear_run();
            // rst_s must leave the previous result untouched.
            check("result_kept_bcd", 32'(result_bcd), 32'(prev_bcd));
            check("result_kept_over", 32'(result_over), 32'(prev_over));
            run_enb(vecs[k].run);
            check("run_count", 32'(count_bcd), 32'(vecs[k].exp_count));
            check("enb3_pulses", 32'(pulses), 32'(vecs[k].exp_pulses));
            drop(vecs[k].exp_count, vecs[k].exp_over, 1'b0);
            prev_bcd  = vecs[k].exp_count;
            prev_over = vecs[k].exp_over;
        end

        // Drop and clear on the same edge: result takes the pre-clear count.
        clear_run();
        run_enb(250);
        check("simul_count", 32'(count_bcd), 32'h250);
        drop(12'h250, 1'b1, 1'b1);

        // Global reset during run-down: no result, all state zero.
        clear_run();
        run_enb(1123);
        check("abort_count", 32'(count_bcd), 32'h123);
        rst_n = 1'b0;
        enb_0 = 1'b0;
        step();
        check("abort_count_zero", 32'(count_bcd), 32'd0);
        check("abort_result_zero", 32'(result_bcd), 32'd0);
        check("abort_over_zero", 32'(result_over), 32'd0);
        check("abort_valid_zero", 32'(result_valid), 32'd0);
        check("abort_enb3_zero", 32'(enb_3), 32'd0);
        step();
        rst_n = 1'b1;
        enb_0 = 1'b1;
        step();
        check("abort_no_valid", 32'(result_valid), 32'd0);
        step();
        step();
        check("resume_count", 32'(count_bcd), 32'h003);
        drop(12'h003, 1'b1, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsadc_bcd_counter.md
Name: dsadc_bcd_counter

Overview:
- Decade (BCD) time-base counter for the dual-slope ADC. It sits directly downstream of the control FSM, which drives `rst_s` and `enb_0`, and feeds `enb_3` back to it.
- Counts clock cycles for both slopes. Signals the end of the fixed integration period when the counter wraps from all-9s to 0.
- Latches the run-down count as the conversion result when `enb_0` falls, and flags over-range.

Parameters:
- N_DIGITS, 3, number of BCD decades. Full scale is 10^N_DIGITS counts.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low global reset
- rst_s  in  1  synchronous clear of the conversion counter, from FSM
- enb_0  in  1  count enable, from FSM; high through integrate and run-down
- enb_3  out  1  one-cycle pulse on first full-scale wrap (end of integration)
- count_bcd  out  4*N_DIGITS  live counter value, digit 0 in bits [3:0]
- result_bcd  out  4*N_DIGITS  latched conversion result
- result_over  out  1  latched over-range flag belonging to result_bcd
- result_valid  out  1  one-cycle pulse when result_bcd/result_over update

Behaviour:
- Priority at each posedge: rst_n > result latch > rst_s > count.
- rst_n=0 sets count_bcd, result_bcd, result_over, result_valid, enb_3, the wrap counter, ovf_flag and enb_0_d to 0.
- rst_s=1 (with rst_n=1):
  - count_bcd=0, wrap counter=0, ovf_flag=0, enb_3=0.
  - result_bcd, result_over and result_valid are not touched by rst_s.
- Count (enb_0=1, rst_s=0):
  - Digit 0 increments. Each digit at 9 with an incoming carry goes to 0 and carries to the next digit.
  - All digits update on the same edge; there is no ripple latency.
  - The digit state machine is 0..9. Codes 10..15 are unreachable; if forced, treat as 9 (wrap to 0 with carry).
- Wrap event: all digits are 9 and enb_0=1.
  - count_bcd becomes 0 on that edge.
  - The 2-bit saturating wrap counter increments.
- First wrap (wrap counter 0->1): enb_3=1 in the cycle count_bcd shows 0, for exactly one cycle.
- Second and later wraps: ovf_flag set, sticky until rst_s/rst_n. No further enb_3 pulses.
- enb_0=0: count holds.
- enb_0_d is a register of enb_0.
- Falling edge (enb_0_d=1, enb_0=0 at the sampling edge):
  - result_bcd <= count_bcd (already frozen).
  - result_over <= ovf_flag OR (wrap counter==0), so a run aborted before integration end is flagged.
  - result_valid=1 for one cycle.
  - Latency: result visible 1 cycle after enb_0 is first sampled low.
- Simultaneous falling edge and rst_s: result takes the pre-clear count and ovf state; the counter clears on the same edge.
- rst_n deasserting mid-run: all state zero, no result_valid. A fresh rst_s is not required; counting resumes if enb_0=1.
- enb_3 has no other assertion source. Outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Package dsadc_pkg holds:
  - DIGIT_W=4, BCD_MAX=4'd9
  - typedef bcd_digit_t
  - typedef wrap_cnt_t (2 bits)
- Sub-module dsadc_bcd_digit: one decade, inputs clk/rst_n/clr/inc, outputs digit/carry_out (combinational carry = inc && digit==9). Instantiate N_DIGITS times with a generate loop.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with enb_0=1 -> all outputs 0. Then rst_n=1 -> count_bcd increments from 000.
2. Integration wrap: rst_s pulse, then enb_0=1 for 1000 cycles:
   - count_bcd=12'h999 after 999 edges.
   - At edge 1000, count_bcd=000 and enb_3=1 for exactly 1 cycle.
3. Normal result: continue 437 cycles, then enb_0=0:
   - count holds 12'h437.
   - Next cycle: result_bcd=12'h437, result_over=0, result_valid pulses once.
4. Over-range: enb_0=1 for 2005 cycles, then drop:
   - Only one enb_3 pulse.
   - result_bcd=12'h005, result_over=1.
   - A subsequent rst_s clears ovf_flag but result_over stays 1.
5. Simultaneous: enb_0 falls on the same edge rst_s=1 at count 12'h250 -> result_bcd=12'h250, count_bcd=0 next cycle.
6. Abort: rst_n=0 at count 12'h123 during run-down -> everything 0, result_valid never pulses. Early abort (enb_0 drops at 12'h040 before any wrap) -> result_over=1.
